// File: rtl/vga_timing_pkg.sv
// Standard 640x480@60 timing constants and a range helper shared by the scan generator.
// Optional feature macro: VGA_MOVE_PAUSE_EN (adds the 'pause' input to vga_scan_gen).
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // Compared as int so an end bound of 1024 does not wrap in 10 bits.
  function automatic logic in_range(logic [9:0] v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction
endpackage

// File: rtl/vga_scan_gen_mod_counter.sv
// Modulo-MOD counter with enable; wrap flags the enabled cycle on which it returns to 0.
module mod_counter #(
  parameter int WIDTH = 10,
  parameter int MOD   = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap  = en & (cnt_q == WIDTH'(MOD - 1));
    cnt_d = cnt_q;
    if (en) cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan timing: pixel strobe prescaler, h/v scan counters, sync/blank decode and move strobe.
// Optional feature macro: VGA_MOVE_PAUSE_EN (pause input freezes the move strobe and frame divider).
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int   PIX_DIV  = 4,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   MOVE_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef VGA_MOVE_PAUSE_EN
  input  logic       pause,
`endif
  output logic       pixpulse,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       move
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int PW       = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_scan_gen: H_TOTAL/V_TOTAL must be <= 1024");
  end
  if (PIX_DIV < 2) begin : g_bad_div
    $error("vga_scan_gen: PIX_DIV must be >= 2");
  end
  if (MOVE_DIV < 1 || MOVE_DIV > 255) begin : g_bad_move
    $error("vga_scan_gen: MOVE_DIV must be 1..255");
  end

  logic [PW-1:0] presc;
  logic          h_wrap, v_wrap_unused;
  logic          move_event, move_en, fdiv_last;
  logic [7:0]    fdiv_q, fdiv_d;

  mod_counter #(.WIDTH(PW), .MOD(PIX_DIV)) u_presc (
    .clk(clk), .rst(rst), .en(1'b1), .cnt(presc), .wrap(pixpulse));

  mod_counter #(.WIDTH(10), .MOD(H_TOTAL)) u_hcnt (
    .clk(clk), .rst(rst), .en(pixpulse), .cnt(hcount), .wrap(h_wrap));

  mod_counter #(.WIDTH(10), .MOD(V_TOTAL)) u_vcnt (
    .clk(clk), .rst(rst), .en(pixpulse & h_wrap), .cnt(vcount), .wrap(v_wrap_unused));

  always_comb begin
    hsync = in_range(hcount, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync = in_range(vcount, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    blank = (int'(hcount) >= H_ACTIVE) | (int'(vcount) >= V_ACTIVE);
    // First strobe after the last visible line: occupancy flags are complete by now.
    move_event = pixpulse & (hcount == 10'd0) & (vcount == 10'(V_ACTIVE));
`ifdef VGA_MOVE_PAUSE_EN
    move_en = move_event & ~pause;
`else
    move_en = move_event;
`endif
    fdiv_last = (fdiv_q == 8'(MOVE_DIV - 1));
    move      = move_en & fdiv_last;
    fdiv_d    = fdiv_q;
    if (move_en) fdiv_d = fdiv_last ? 8'd0 : fdiv_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) fdiv_q <= 8'd0;
    else      fdiv_q <= fdiv_d;
  end
endmodule

// File: tb/tb_vga_scan_gen.sv
// Randomized reset/run bench; expectations come from a closed-form model of elapsed clocks.
module tb_vga_scan_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int k = 0;

  // std: default 640x480; s1/s3: small frame, PIX_DIV=3, active-high syncs, MOVE_DIV 1 and 3
  logic       pp_a, hs_a, vs_a, bl_a, mv_a;
  logic [9:0] hc_a, vc_a;
  logic       pp_b, hs_b, vs_b, bl_b, mv_b;
  logic [9:0] hc_b, vc_b;
  logic       pp_c, hs_c, vs_c, bl_c, mv_c;
  logic [9:0] hc_c, vc_c;
`ifdef VGA_MOVE_PAUSE_EN
  logic pause = 1'b0;
`endif

  vga_scan_gen u_std (
    .clk(clk), .rst(rst),
`ifdef VGA_MOVE_PAUSE_EN
    .pause(pause),
`endif
    .pixpulse(pp_a), .hcount(hc_a), .vcount(vc_a),
    .hsync(hs_a), .vsync(vs_a), .blank(bl_a), .move(mv_a));

  vga_scan_gen #(.PIX_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                 .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                 .SYNC_POL(1'b1), .MOVE_DIV(1)) u_s1 (
    .clk(clk), .rst(rst),
`ifdef VGA_MOVE_PAUSE_EN
    .pause(pause),
`endif
    .pixpulse(pp_b), .hcount(hc_b), .vcount(vc_b),
    .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .move(mv_b));

  vga_scan_gen #(.PIX_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                 .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                 .SYNC_POL(1'b1), .MOVE_DIV(3)) u_s3 (
    .clk(clk), .rst(rst),
`ifdef VGA_MOVE_PAUSE_EN
    .pause(pause),
`endif
    .pixpulse(pp_c), .hcount(hc_c), .vcount(vc_c),
    .hsync(hs_c), .vsync(vs_c), .blank(bl_c), .move(mv_c));

  typedef struct {
    int pix, h, v, hs, vs, bl, mv;
  } exp_t;

  // k = clocks since reset released; strobes taken = k/pd; move events occur at strobe
  // index e0 = va*ht within each frame, and prior events decide the divider phase.
  function automatic exp_t model(int kk, int pd, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, int pol, int md);
    exp_t e;
    int ht, vt, fr, s, n, e0, prior;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    fr = ht * vt;
    s  = kk / pd;
    n  = s % fr;
    e.pix = ((kk % pd) == pd - 1) ? 1 : 0;
    e.h   = n % ht;
    e.v   = n / ht;
    e.hs  = (e.h >= ha + hf && e.h < ha + hf + hsw) ? pol : 1 - pol;
    e.vs  = (e.v >= va + vf && e.v < va + vf + vsw) ? pol : 1 - pol;
    e.bl  = (e.h >= ha || e.v >= va) ? 1 : 0;
    e0    = va * ht;
    prior = (s > e0) ? (s - e0 - 1) / fr + 1 : 0;
    e.mv  = (e.pix == 1 && n == e0 && (prior % md) == md - 1) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0d exp=%0d", tag, k, got, exp);
    end
  endtask

  int mv_b_cnt, mv_c_cnt, hs_a_low;

  task automatic check_all();
    exp_t ea, eb;
    ea = model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1);
    eb = model(k, 3, 16, 2, 4, 3, 6, 1, 2, 1, 1, 1);
    chk("std_pix",   int'(pp_a), ea.pix);
    chk("std_h",     int'(hc_a), ea.h);
    chk("std_v",     int'(vc_a), ea.v);
    chk("std_hsync", int'(hs_a), ea.hs);
    chk("std_vsync", int'(vs_a), ea.vs);
    chk("std_blank", int'(bl_a), ea.bl);
    chk("std_move",  int'(mv_a), ea.mv);
    chk("s1_pix",    int'(pp_b), eb.pix);
    chk("s1_h",      int'(hc_b), eb.h);
    chk("s1_v",      int'(vc_b), eb.v);
    chk("s1_hsync",  int'(hs_b), eb.hs);
    chk("s1_vsync",  int'(vs_b), eb.vs);
    chk("s1_blank",  int'(bl_b), eb.bl);
    chk("s1_move",   int'(mv_b), eb.mv);
    chk("s3_move",   int'(mv_c), model(k, 3, 16, 2, 4, 3, 6, 1, 2, 1, 1, 3).mv);
    if (mv_b) mv_b_cnt++;
    if (mv_c) mv_c_cnt++;
    if (!hs_a) hs_a_low++;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) k = 0;
    else      k++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    mv_b_cnt = 0; mv_c_cnt = 0; hs_a_low = 0;
    rst = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    // 8000 clks: std covers two line wraps, small frames cover 11 move events
    repeat (8000) cyc();
    chk("s1_move_count", mv_b_cnt, 11);
    chk("s3_move_count", mv_c_cnt, 3);
    chk("std_hsync_low_clks", hs_a_low, 768);
    for (int ep = 0; ep < 6; ep++) begin
      rst = 1'b0;
      repeat ($urandom_range(4, 1)) cyc();
      rst = 1'b1;
      repeat ($urandom_range(2500, 100)) cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
